// File: rtl/packet_source.sv
// packet_source: generates fixed-length packets over a two-phase req/ack
// handshake. Each packet is a header flit (destination address) followed by
// body/tail flits carrying a payload; single-flit packets use type 2'b11.
//
// Ports:
//   clk          - clock, rising-edge active
//   reset        - asynchronous, active-low reset
//   enable       - allows a new packet to start (sampled only while idle)
//   ack          - two-phase acknowledge, one toggle per accepted flit
//   req          - two-phase request, one toggle per presented flit
//   data         - current flit, stable from its req toggle to its ack toggle
//   busy         - a packet is in flight
//   done         - MAX_PACKETS packets have completed (never if MAX_PACKETS=0)
//   packets_sent - completed-packet count, saturating at 16'hFFFF
//
// Build option: define PACKET_SOURCE_LFSR_EN to take payloads from a 16-bit
// Fibonacci LFSR (seed 16'hACE1 ^ ID) instead of a sequence counter.
module packet_source #(
  parameter int ID               = 0,
  parameter int DESTINATION      = 0,
  parameter int MAX_PACKETS      = 2,
  parameter int FLITS_PER_PACKET = 3,
  parameter int SIZE             = 8,
  parameter int DEST_BITS        = 4,
  parameter int GAP              = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            ack,
  output logic            req,
  output logic [SIZE-1:0] data,
  output logic            busy,
  output logic            done,
  output logic [15:0]     packets_sent
);

  localparam int PW = SIZE - 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_DONE} state_t;

  state_t          state, state_nxt;
  logic            ack_old;
  logic            ack_received;
  logic [7:0]      flit_cnt;
  logic [7:0]      gap_cnt;
  logic [15:0]     pkt_inc;
  logic            idle_limit;
  logic            limit_hit;
  logic            last_flit;
  logic            start;
  logic            flit_adv;
  logic            pkt_end;
  logic [PW-1:0]   payload;
  logic [SIZE-1:0] header_flit;
  logic [SIZE-1:0] next_flit;

  assign ack_received = ack ^ ack_old;
  assign last_flit    = (flit_cnt == 8'(FLITS_PER_PACKET - 1));
  assign start        = (state == S_IDLE) && enable && !idle_limit;
  assign flit_adv     = (state == S_WAIT) && ack_received && !last_flit;
  assign pkt_end      = (state == S_WAIT) && ack_received && last_flit;

  always_comb begin
    pkt_inc    = (packets_sent == 16'hFFFF) ? packets_sent : packets_sent + 16'd1;
    idle_limit = (MAX_PACKETS != 0) && ({16'd0, packets_sent} >= 32'(MAX_PACKETS));
    limit_hit  = (MAX_PACKETS != 0) && ({16'd0, pkt_inc} >= 32'(MAX_PACKETS));
  end

  always_comb begin
    header_flit                  = '0;
    header_flit[DEST_BITS-1:0]   = DEST_BITS'(DESTINATION);
    header_flit[SIZE-1:SIZE-2]   = (FLITS_PER_PACKET == 1) ? 2'b11 : 2'b10;
    // the flit about to be driven is the tail when it is index FLITS_PER_PACKET-1
    next_flit = {(flit_cnt == 8'(FLITS_PER_PACKET - 2)) ? 2'b01 : 2'b00, payload};
  end

`ifdef PACKET_SOURCE_LFSR_EN
  localparam logic [15:0] SEED = 16'hACE1 ^ 16'(ID);

  logic [15:0]    lfsr, lfsr_nxt;
  logic [PW+15:0] lfsr_ext;

  // x^16+x^14+x^13+x^11+1; the payload is the freshly advanced state
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign lfsr_ext = {{PW{1'b0}}, lfsr_nxt};
  assign payload  = lfsr_ext[PW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        lfsr <= SEED;
    else if (flit_adv) lfsr <= lfsr_nxt;
  end
`else
  logic [PW-1:0] seq_cnt;

  assign payload = seq_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        seq_cnt <= '0;
    else if (flit_adv) seq_cnt <= seq_cnt + PW'(1);
  end
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_WAIT;
      S_WAIT: begin
        if (pkt_end) begin
          if (limit_hit)    state_nxt = S_DONE;
          else if (GAP > 0) state_nxt = S_GAP;
          else              state_nxt = S_IDLE;
        end
      end
      S_GAP:  if (gap_cnt == 8'(GAP - 1)) state_nxt = S_IDLE;
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy = (state == S_WAIT);
    done = (state == S_DONE);
  end

  // handshake and flit datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_old      <= 1'b0;
      req          <= 1'b0;
      data         <= '0;
      flit_cnt     <= '0;
      gap_cnt      <= '0;
      packets_sent <= '0;
    end else begin
      ack_old <= ack;
      if (start) begin
        req      <= ~req;
        data     <= header_flit;
        flit_cnt <= '0;
      end
      if (flit_adv) begin
        req      <= ~req;
        data     <= next_flit;
        flit_cnt <= flit_cnt + 8'd1;
      end
      if (pkt_end) begin
        packets_sent <= pkt_inc;
        gap_cnt      <= '0;
      end
      if (state == S_GAP) gap_cnt <= gap_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_packet_source.sv
// Directed bench for packet_source: four instances with different parameter
// sets (index 0: DESTINATION=5; 1: single-flit x3; 2: GAP=4; 3: SIZE=18).
module tb_packet_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst  [4];
  logic        en   [4];
  logic        ack  [4];
  logic        req  [4];
  logic        busy [4];
  logic        done [4];
  logic [15:0] pk   [4];
  logic        seen [4];
  logic [7:0]  d8   [3];
  logic [17:0] d18;

  packet_source #(.DESTINATION(5)) u_a (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .ack(ack[0]), .req(req[0]),
    .data(d8[0]), .busy(busy[0]), .done(done[0]), .packets_sent(pk[0]));

  packet_source #(.FLITS_PER_PACKET(1), .DESTINATION(3), .MAX_PACKETS(3)) u_b (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .ack(ack[1]), .req(req[1]),
    .data(d8[1]), .busy(busy[1]), .done(done[1]), .packets_sent(pk[1]));

  packet_source #(.GAP(4)) u_c (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .ack(ack[2]), .req(req[2]),
    .data(d8[2]), .busy(busy[2]), .done(done[2]), .packets_sent(pk[2]));

  packet_source #(.SIZE(18), .ID(0)) u_d (
    .clk(clk), .reset(rst[3]), .enable(en[3]), .ack(ack[3]), .req(req[3]),
    .data(d18), .busy(busy[3]), .done(done[3]), .packets_sent(pk[3]));

  function automatic logic [31:0] dat(input int i);
    return (i == 3) ? 32'(d18) : 32'(d8[i]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait (bounded) for the next req toggle of instance i, then check its flit
  task automatic flit(input int i, input string tag, input logic [31:0] exp);
    int n = 0;
    while (req[i] === seen[i] && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tog"}, 32'(req[i] !== seen[i]), 32'd1);
    chk(tag, dat(i), exp);
    seen[i] = req[i];
  endtask

  task automatic give_ack(input int i);
    @(negedge clk);
    ack[i] = ~ack[i];
  endtask

  logic [7:0] exp_a [6] = '{8'h85, 8'h00, 8'h41, 8'h85, 8'h02, 8'h43};
  int         n_cyc;

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0; ack[i] = 1'b0; seen[i] = 1'b0;
    end
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_req",  32'(req[0]),  32'd0);
    chk("rst_data", dat(0),       32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_pk",   32'(pk[0]),   32'd0);
    for (int i = 0; i < 4; i++) rst[i] = 1'b1;

    // ack toggle while idle and disabled is ignored
    @(negedge clk);
    ack[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ack_req",  32'(req[0]),  32'd0);
    chk("idle_ack_busy", 32'(busy[0]), 32'd0);
    chk("idle_ack_pk",   32'(pk[0]),   32'd0);

    // two 3-flit packets to destination 5
    en[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      flit(0, "A_flit", 32'(exp_a[j]));
      chk("A_busy", 32'(busy[0]), 32'd1);
      give_ack(0);
    end
    @(negedge clk);
    chk("A_done", 32'(done[0]), 32'd1);
    chk("A_pk",   32'(pk[0]),   32'd2);
    chk("A_busy_end", 32'(busy[0]), 32'd0);

    // DONE holds req/data and ignores acks
    give_ack(0);
    repeat (3) @(negedge clk);
    chk("A_done_req",  32'(req[0]),  32'(seen[0]));
    chk("A_done_data", dat(0),       32'h43);
    chk("A_done_hold", 32'(done[0]), 32'd1);

    // reset mid-packet after the body ack
    rst[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    seen[0] = 1'b0;
    flit(0, "A_r_hdr", 32'h85);
    give_ack(0);
    flit(0, "A_r_body", 32'h00);
    give_ack(0);
    flit(0, "A_r_tail", 32'h41);
    rst[0] = 1'b0;
    #1;
    chk("A_mid_req",  32'(req[0]),  32'd0);
    chk("A_mid_data", dat(0),       32'd0);
    chk("A_mid_busy", 32'(busy[0]), 32'd0);
    chk("A_mid_done", 32'(done[0]), 32'd0);
    chk("A_mid_pk",   32'(pk[0]),   32'd0);
    @(negedge clk);
    rst[0] = 1'b1;
    seen[0] = 1'b0;
    flit(0, "A_re_hdr", 32'h85);
    chk("A_re_pk", 32'(pk[0]), 32'd0);
    give_ack(0);
    flit(0, "A_re_body", 32'h00);
    en[0] = 1'b0;

    // three single-flit packets
    en[1] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      flit(1, "B_flit", 32'hC3);
      give_ack(1);
    end
    @(negedge clk);
    chk("B_done", 32'(done[1]), 32'd1);
    chk("B_pk",   32'(pk[1]),   32'd3);
    give_ack(1);
    repeat (3) @(negedge clk);
    chk("B_no_4th", 32'(req[1]), 32'(seen[1]));

    // GAP=4 spacing between packets
    en[2] = 1'b1;
    flit(2, "C_hdr", 32'h80);
    give_ack(2);
    flit(2, "C_body", 32'h00);
    give_ack(2);
    flit(2, "C_tail", 32'h41);
    give_ack(2);
    n_cyc = 0;
    while (req[2] === seen[2] && n_cyc < 20) begin
      @(negedge clk);
      n_cyc++;
      if (n_cyc == 3) chk("C_gap_busy", 32'(busy[2]), 32'd0);
    end
    chk("C_gap_lat", 32'(n_cyc), 32'd6);
    chk("C_hdr2",    dat(2),     32'h80);
    chk("C_pk",      32'(pk[2]), 32'd1);
    seen[2] = req[2];
    en[2] = 1'b0;

    // wide flit: header and first body payload
    en[3] = 1'b1;
    flit(3, "D_hdr", 32'h20000);
    give_ack(3);
`ifdef PACKET_SOURCE_LFSR_EN
    flit(3, "D_body", 32'h059C3);
`else
    flit(3, "D_body", 32'h00000);
`endif
    en[3] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_source.md
PACKET_SOURCE -- requirements
Module: packet_source

Interface
REQ-001 Parameter ID, default 0: source identifier; XORed into the LFSR seed.
REQ-002 Parameter DESTINATION, default 0: destination address carried in header flits.
REQ-003 Parameter MAX_PACKETS, default 2: packets to send before done; 0 means unlimited.
REQ-004 Parameter FLITS_PER_PACKET, default 3, range 1..255: flits per packet, header included.
REQ-005 Parameter SIZE, default 8, minimum DEST_BITS+2: flit width.
REQ-006 Parameter DEST_BITS, default 4: destination field width.
REQ-007 Parameter GAP, default 0, range 0..255: idle cycles inserted after each packet.
REQ-008 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-009 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port enable, input, 1 bit: permits a new packet to start; sampled only in IDLE.
REQ-011 Port ack, input, 1 bit: two-phase acknowledge; each toggle acknowledges one flit.
REQ-012 Port req, output, 1 bit: two-phase request; each toggle presents one new flit.
REQ-013 Port data, output, SIZE bits: current flit; held stable from its req toggle until its ack toggle.
REQ-014 Port busy, output, 1 bit: high while a packet is in flight (state WAIT).
REQ-015 Port done, output, 1 bit: high once MAX_PACKETS packets have completed (never with MAX_PACKETS=0).
REQ-016 Port packets_sent, output, 16 bits: completed-packet count; saturates at 16'hFFFF.

Function
REQ-017 Flit type is data[SIZE-1:SIZE-2]: 2'b10 header, 2'b00 body, 2'b01 tail, 2'b11 single-flit packet.
REQ-018 Header and single-flit flits place DESTINATION[DEST_BITS-1:0] in the low bits; all other bits are zero.
REQ-019 Body and tail flits carry a payload in data[SIZE-3:0].
REQ-020 The payload source advances once per body/tail flit sent.
REQ-021 ack_received = ack XOR ack_old, where ack_old is ack registered every cycle.
REQ-022 States are IDLE, WAIT, GAP and DONE.
REQ-023 IDLE -> WAIT when enable=1 and the limit is not reached; on that same edge, drive the first flit and toggle req.
REQ-024 In WAIT on ack_received with further flits remaining, on that same edge drive the next flit, toggle req and stay in WAIT.
REQ-025 In WAIT on ack_received for the last flit, increment packets_sent.
REQ-026 After the last flit: go to DONE if the limit is now reached; else GAP if GAP>0; else IDLE.
REQ-027 GAP counts GAP cycles, then -> IDLE; a new packet therefore starts no earlier than GAP+1 cycles after the final ack edge.
REQ-028 DONE is terminal until reset; req and data hold their last values.
REQ-029 ack toggles outside WAIT are ignored; they update ack_old only.
REQ-030 Deasserting enable mid-packet does not stall the packet; enable only gates packet starts.
REQ-031 The in-packet flit counter is 8 bits and resets to 0 at each packet start.

Reset
REQ-032 While reset=0, asynchronously: req=0, data=0, busy=0, done=0, packets_sent=0, ack_old=0, state=IDLE, all counters 0, payload source at its seed.
REQ-033 Reset asserted mid-packet abandons the packet; the abandoned packet is not counted.

Configuration
REQ-034 Macro PACKET_SOURCE_LFSR_EN selects the payload source.
REQ-035 With PACKET_SOURCE_LFSR_EN defined: payload = low bits of a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded 16'hACE1 XOR ID.
REQ-036 In LFSR mode, when SIZE-2 > 16 the payload is zero-extended.
REQ-037 Without PACKET_SOURCE_LFSR_EN: payload = a (SIZE-2)-bit sequence counter, reset to 0, wrapping modulo 2^(SIZE-2).

Verification
REQ-038 Defaults except DESTINATION=5, counter mode, enable=1, ack toggled 2 cycles after each req toggle -> data sequence 85,00,41,85,02,43 (hex); then done=1 and packets_sent=2.
REQ-039 FLITS_PER_PACKET=1, DESTINATION=3, MAX_PACKETS=3 -> three flits of 8'hC3, exactly three req toggles, then done=1.
REQ-040 GAP=4 -> the second header's req toggle occurs exactly 5 cycles after the edge that sampled the first packet's tail ack.
REQ-041 ack toggled while in IDLE with enable=0 -> no req toggle, state stays IDLE, packets_sent unchanged.
REQ-042 reset asserted after the body ack -> all outputs 0 immediately; after release, the first header is resent and packets_sent=0.
REQ-043 PACKET_SOURCE_LFSR_EN defined, ID=0, SIZE=18 -> first body payload equals LFSR state after one advance from seed 16'hACE1, zero-extended to 16 bits.
